// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and default widths for the data memory arbiter.
package data_mem_pkg;

  localparam int DATA_AW = 9;
  localparam int DATA_DW = 16;

  typedef enum logic {ARB, LOCK1} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} rd_owner_e;

  typedef struct packed {
    logic               we;
    logic [DATA_AW-1:0] addr;
    logic [DATA_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of both requester ports plus the data_mem pins seen by the arbiter.
interface data_mem_arbiter_if
  import data_mem_pkg::*;
#(
  parameter int AW = DATA_AW,
  parameter int DW = DATA_DW
) ();

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_lock;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  mem_q,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_wen, mem_a, mem_d
  );

  // Requesters and memory side.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output mem_q,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_wen, mem_a, mem_d
  );

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with an optional fixed-priority override on ties.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_en,
  input  logic       prio_port,
  output logic [1:0] gnt
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (prio_en) gnt[prio_port] = 1'b1;
      else         gnt[~last]     = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port synchronous data memory between the CPU (port 0) and the AES DMA (port 1).
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int AW       = DATA_AW,
  parameter int DW       = DATA_DW,
  parameter int MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  data_mem_arbiter_if.slave bus
);

  localparam int            WW        = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  arb_state_e    state, state_nxt;
  logic          last;
  logic [WW-1:0] wait_cnt;
  rd_owner_e     rd_owner;
  logic [1:0]    req, arb_gnt, gnt;
  logic          force_m0;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req      = {bus.m1_req, bus.m0_req};
  assign force_m0 = (wait_cnt == WAIT_LAST);

  rr_arb2 u_rr_arb2 (
    .req       (req),
    .last      (last),
    .prio_en   (state == LOCK1),
    .prio_port (!force_m0),
    .gnt       (arb_gnt)
  );

  // Grants are held low during reset so the memory never sees a stray write.
  assign gnt = arb_gnt & {2{RST_N}};

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (gnt[1] && bus.m1_lock) state_nxt = LOCK1;
      LOCK1:   if (!bus.m1_lock)          state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ARB;
      last     <= 1'b1;
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      state <= state_nxt;

      if (gnt[0])      last <= 1'b0;
      else if (gnt[1]) last <= 1'b1;

      if (state_nxt != LOCK1 || gnt[0])
        wait_cnt <= '0;
      else if (state == LOCK1 && bus.m0_req && wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + WW'(1);

      if (gnt[0] && !bus.m0_we)      rd_owner <= OWN_M0;
      else if (gnt[1] && !bus.m1_we) rd_owner <= OWN_M1;
      else                           rd_owner <= OWN_NONE;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[0]) begin
      sel_we    = bus.m0_we;
      sel_addr  = bus.m0_addr;
      sel_wdata = bus.m0_wdata;
    end else if (gnt[1]) begin
      sel_we    = bus.m1_we;
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
    end
  end

  assign bus.mem_wen = sel_we;
  assign bus.mem_a   = sel_addr;
  assign bus.mem_d   = sel_wdata;

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = (rd_owner == OWN_M0);
  assign bus.m1_rvalid = (rd_owner == OWN_M1);
  assign bus.m0_rdata  = (rd_owner == OWN_M0) ? bus.mem_q : '0;
  assign bus.m1_rdata  = (rd_owner == OWN_M1) ? bus.mem_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and random checks of data_mem_arbiter against a behavioural data_mem and scoreboard.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  logic CLK      = 1'b0;
  logic RST_N    = 1'b0;
  logic mem_load = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  always #5 CLK = ~CLK;

  data_mem_arbiter_if bus ();

  data_mem_arbiter #(.MAX_WAIT(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  function automatic logic [15:0] init_val(input logic [8:0] a);
    return 16'hC000 | {7'b0, a};
  endfunction

  // Behavioural data_mem: registered read, read-during-write returns old data.
  logic [15:0] mem [0:511];
  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(9'(i));
      bus.mem_q <= '0;
    end else begin
      if (bus.mem_wen) mem[bus.mem_a] <= bus.mem_d;
      bus.mem_q <= mem[bus.mem_a];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [8:0] a, input logic [15:0] d);
    bus.m0_req = r; bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [8:0] a, input logic [15:0] d,
                        input logic lk);
    bus.m1_req = r; bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_lock = lk;
  endtask

  logic        exp_port;
  mem_req_t    r0, r1;
  logic        p0, p1, lk, ev0, ev1;
  logic [15:0] ed0, ed1;
  int          w0, w1;
  logic [15:0] sb_mem [0:15];

  initial begin
    // Reset with both ports requesting.
    set_m0(1'b1, 1'b0, 9'h003, 16'h0);
    set_m1(1'b1, 1'b0, 9'h004, 16'h0, 1'b0);
    tick(); mem_load = 1'b0; sample();
    check("rst_m0_gnt",    bus.m0_gnt,    0);
    check("rst_m1_gnt",    bus.m1_gnt,    0);
    check("rst_mem_wen",   bus.mem_wen,   0);
    check("rst_mem_a",     bus.mem_a,     0);
    check("rst_m0_rvalid", bus.m0_rvalid, 0);
    check("rst_m1_rvalid", bus.m1_rvalid, 0);
    check("rst_m0_rdata",  bus.m0_rdata,  0);

    tick(); RST_N = 1'b1; sample();
    check("rel_m0_gnt", bus.m0_gnt, 1);
    check("rel_m1_gnt", bus.m1_gnt, 0);
    check("rel_mem_a",  bus.mem_a,  9'h003);
    tick(); set_m0(1'b0, 1'b0, 9'h0, 16'h0); set_m1(1'b0, 1'b0, 9'h0, 16'h0, 1'b0); sample();
    check("rel_m0_rvalid", bus.m0_rvalid, 1);
    check("rel_m0_rdata",  bus.m0_rdata,  16'hC003);
    check("rel_m1_rvalid", bus.m1_rvalid, 0);

    // Single port write then read back.
    tick(); set_m0(1'b1, 1'b1, 9'h010, 16'h00A5); sample();
    check("wr_m0_gnt",  bus.m0_gnt,  1);
    check("wr_mem_wen", bus.mem_wen, 1);
    check("wr_mem_a",   bus.mem_a,   9'h010);
    check("wr_mem_d",   bus.mem_d,   16'h00A5);
    tick(); set_m0(1'b1, 1'b0, 9'h010, 16'h0); sample();
    check("rd_m0_gnt",    bus.m0_gnt,    1);
    check("rd_mem_wen",   bus.mem_wen,   0);
    check("rd_m0_rvalid", bus.m0_rvalid, 0);
    tick(); set_m0(1'b0, 1'b0, 9'h0, 16'h0); sample();
    check("rd_m0_rvalid2", bus.m0_rvalid, 1);
    check("rd_m0_rdata",   bus.m0_rdata,  16'h00A5);
    check("rd_m1_rvalid",  bus.m1_rvalid, 0);
    check("rd_m1_rdata",   bus.m1_rdata,  0);
    check("idle_mem_a",    bus.mem_a,     0);
    check("idle_gnt",      {bus.m1_gnt, bus.m0_gnt}, 0);

    // Tie: m0 was granted last, so m1 wins the first tie, then strict alternation.
    exp_port = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); set_m0(1'b1, 1'b0, 9'h001, 16'h0); set_m1(1'b1, 1'b0, 9'h002, 16'h0, 1'b0); sample();
      check("tie_gnt0", bus.m0_gnt, exp_port == 1'b0);
      check("tie_gnt1", bus.m1_gnt, exp_port == 1'b1);
      if (i > 0) begin
        check("tie_rv0", bus.m0_rvalid, exp_port == 1'b1);
        check("tie_rv1", bus.m1_rvalid, exp_port == 1'b0);
        check("tie_rd0", bus.m0_rdata, (exp_port == 1'b1) ? 16'hC001 : 16'h0);
        check("tie_rd1", bus.m1_rdata, (exp_port == 1'b0) ? 16'hC002 : 16'h0);
      end
      exp_port = ~exp_port;
    end
    tick(); set_m0(1'b0, 1'b0, 9'h0, 16'h0); set_m1(1'b0, 1'b0, 9'h0, 16'h0, 1'b0); sample();
    check("tie_last_rv0", bus.m0_rvalid, 1);
    check("tie_last_rd0", bus.m0_rdata,  16'hC001);
    check("tie_last_rv1", bus.m1_rvalid, 0);

    // m1 alone, then a tie with m1_lock raised: lock alone does not steal the tie.
    tick(); set_m1(1'b1, 1'b0, 9'h002, 16'h0, 1'b0); sample();
    check("pl_gnt1", bus.m1_gnt, 1);
    tick(); set_m0(1'b1, 1'b0, 9'h001, 16'h0); set_m1(1'b1, 1'b0, 9'h002, 16'h0, 1'b1); sample();
    check("arb_lock_gnt0", bus.m0_gnt, 1);
    check("arb_lock_gnt1", bus.m1_gnt, 0);

    // Lock burst: m0 forced through on its 8th waiting cycle.
    tick(); set_m0(1'b0, 1'b0, 9'h0, 16'h0); sample();
    check("lk_start_gnt1", bus.m1_gnt, 1);
    tick(); set_m0(1'b1, 1'b0, 9'h001, 16'h0);
    for (int k = 1; k <= 7; k++) begin
      sample();
      check("lk_wait_gnt0", bus.m0_gnt, 0);
      check("lk_wait_gnt1", bus.m1_gnt, 1);
      tick();
    end
    sample();
    check("lk_force_gnt0", bus.m0_gnt, 1);
    check("lk_force_gnt1", bus.m1_gnt, 0);
    tick(); set_m0(1'b0, 1'b0, 9'h0, 16'h0); sample();
    check("lk_resume_gnt1", bus.m1_gnt,    1);
    check("lk_resume_rv0",  bus.m0_rvalid, 1);
    check("lk_resume_rd0",  bus.m0_rdata,  16'hC001);
    tick(); set_m0(1'b1, 1'b0, 9'h001, 16'h0); sample();
    check("lk_still_gnt1", bus.m1_gnt, 1);
    check("lk_still_gnt0", bus.m0_gnt, 0);

    // Drop the lock: this cycle still arbitrates as LOCK1, then alternation resumes.
    tick(); bus.m1_lock = 1'b0; sample();
    check("unlk_gnt1", bus.m1_gnt, 1);
    tick(); sample();
    check("unlk_arb0", bus.m0_gnt, 1);
    tick(); sample();
    check("unlk_arb1", bus.m1_gnt, 1);
    tick(); sample();
    check("unlk_arb2", bus.m0_gnt, 1);
    tick(); set_m0(1'b0, 1'b0, 9'h0, 16'h0); set_m1(1'b0, 1'b0, 9'h0, 16'h0, 1'b0); sample();
    check("unlk_rv0", bus.m0_rvalid, 1);

    // Reset right after a granted m1 read drops the pending return.
    tick(); set_m1(1'b1, 1'b0, 9'h005, 16'h0, 1'b0); sample();
    check("r5_gnt1", bus.m1_gnt, 1);
    tick(); set_m1(1'b0, 1'b0, 9'h0, 16'h0, 1'b0); set_m0(1'b1, 1'b0, 9'h003, 16'h0); RST_N = 1'b0; sample();
    check("r5_rv1",     bus.m1_rvalid, 0);
    check("r5_rd1",     bus.m1_rdata,  0);
    check("r5_gnt0",    bus.m0_gnt,    0);
    check("r5_mem_wen", bus.mem_wen,   0);
    tick(); RST_N = 1'b1; set_m1(1'b1, 1'b0, 9'h004, 16'h0, 1'b0); sample();
    check("r5_rel_gnt0", bus.m0_gnt, 1);
    check("r5_rel_gnt1", bus.m1_gnt, 0);
    tick(); set_m0(1'b0, 1'b0, 9'h0, 16'h0); set_m1(1'b0, 1'b0, 9'h0, 16'h0, 1'b0); sample();
    check("r5_rel_rv0", bus.m0_rvalid, 1);
    check("r5_rel_rd0", bus.m0_rdata,  16'hC003);
    check("r5_rel_rv1", bus.m1_rvalid, 0);

    // Random mixed traffic against a scoreboard of addresses 0..15.
    for (int i = 0; i < 16; i++) sb_mem[i] = init_val(9'(i));
    p0 = 1'b0; p1 = 1'b0; lk = 1'b0; ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0; w0 = 0; w1 = 0;
    r0 = '0; r1 = '0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; r0.we = 1'($urandom_range(0, 1)); r0.addr = 9'($urandom_range(0, 15)); r0.wdata = 16'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; r1.we = 1'($urandom_range(0, 1)); r1.addr = 9'($urandom_range(0, 15)); r1.wdata = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      set_m0(p0, r0.we, r0.addr, r0.wdata);
      set_m1(p1, r1.we, r1.addr, r1.wdata, lk);
      sample();
      check("rnd_rv0", bus.m0_rvalid, ev0);
      check("rnd_rv1", bus.m1_rvalid, ev1);
      check("rnd_rd0", bus.m0_rdata, ev0 ? ed0 : 16'h0);
      check("rnd_rd1", bus.m1_rdata, ev1 ? ed1 : 16'h0);
      check("rnd_double_gnt", bus.m0_gnt & bus.m1_gnt, 0);
      check("rnd_gnt0_noreq", bus.m0_gnt & ~p0, 0);
      check("rnd_gnt1_noreq", bus.m1_gnt & ~p1, 0);
      ev0 = 1'b0; ev1 = 1'b0;
      if (bus.m0_gnt) begin
        check("rnd_mem_a0",   bus.mem_a,   r0.addr);
        check("rnd_mem_wen0", bus.mem_wen, r0.we);
        if (r0.we) begin
          check("rnd_mem_d0", bus.mem_d, r0.wdata);
          sb_mem[r0.addr[3:0]] = r0.wdata;
        end else begin
          ev0 = 1'b1; ed0 = sb_mem[r0.addr[3:0]];
        end
        p0 = 1'b0; w0 = 0;
      end else if (p0) begin
        w0++;
      end
      if (bus.m1_gnt) begin
        check("rnd_mem_a1",   bus.mem_a,   r1.addr);
        check("rnd_mem_wen1", bus.mem_wen, r1.we);
        if (r1.we) begin
          check("rnd_mem_d1", bus.mem_d, r1.wdata);
          sb_mem[r1.addr[3:0]] = r1.wdata;
        end else begin
          ev1 = 1'b1; ed1 = sb_mem[r1.addr[3:0]];
        end
        p1 = 1'b0; w1 = 0;
      end else if (p1) begin
        w1++;
      end
      if (!bus.m0_gnt && !bus.m1_gnt) check("rnd_idle_wen", bus.mem_wen, 0);
      check("rnd_starve0", w0 > 16, 0);
      check("rnd_starve1", w1 > 16, 0);
    end
    tick(); set_m0(1'b0, 1'b0, 9'h0, 16'h0); set_m1(1'b0, 1'b0, 9'h0, 16'h0, 1'b0); sample();
    check("rnd_end_rv0", bus.m0_rvalid, ev0);
    check("rnd_end_rv1", bus.m1_rvalid, ev1);
    check("rnd_end_rd0", bus.m0_rdata, ev0 ? ed0 : 16'h0);
    check("rnd_end_rd1", bus.m1_rdata, ev1 ? ed1 : 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
